// File: rtl/iic_ctrl.sv
// Byte-level I2C master for 24Cxx EEPROMs: single write or random read per request.
// Latency: done pulses 1 + ticks*CNT_MAX clocks after the accepting edge (write16 = 152 ticks).
// Backpressure: requests are ignored while busy; upstream holds iic_start until done.
module iic_ctrl #(
  parameter int          SYS_CLK_FREQ = 50_000_000,
  parameter int          SCL_FREQ     = 250_000,
  parameter logic [6:0]  DEVICE_ADDR  = 7'b1010_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iic_start,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic        addr_mem,
  input  logic [15:0] data_addr,
  input  logic [7:0]  wr_data,
  output logic        iic_wr_rd_done,
  output logic [7:0]  rd_data,
  output logic        busy,
  output logic        ack_err,
  output logic        scl,
  inout  wire         sda
);

  localparam int CNT_MAX = SYS_CLK_FREQ / (SCL_FREQ * 4);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [3:0] {
    IDLE, START, DEV_W, ACK_DW, ADDR_H, ACK_AH, ADDR_L, ACK_AL,
    WR_DATA, ACK_WD, RESTART, DEV_R, ACK_DR, RD_DATA, NACK_M, STOP
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [1:0]    ph;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sh, rx_sh;
  logic          ack_bit, rx_done;
  logic          op_rd, a16;
  logic [15:0]   addr_q;
  logic [7:0]    wdat_q;
  logic          start_q, sda_s1, sda_s2;
  logic          sda_oe;
  logic          scl_c, sda_low_c;

  logic accept, step, last_bit, scl_mid, is_ack;

  assign accept   = (state == IDLE) && !busy && iic_start && !start_q && (wr_en ^ rd_en);
  assign step     = tick && (ph == 2'd3);
  assign last_bit = (bit_cnt == 3'd7);
  assign scl_mid  = (ph == 2'd1) || (ph == 2'd2);
  assign is_ack   = (state == ACK_DW) || (state == ACK_AH) || (state == ACK_AL) ||
                    (state == ACK_WD) || (state == ACK_DR);

  // Open-drain: only ever pull low, the external pull-up supplies the high level.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    scl_c     = 1'b1;
    sda_low_c = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = START;
      START: begin
        scl_c     = (ph != 2'd3);
        sda_low_c = ph[1];
        if (step) state_nxt = DEV_W;
      end
      RESTART: begin
        scl_c     = scl_mid;
        sda_low_c = ph[1];
        if (step) state_nxt = DEV_R;
      end
      STOP: begin
        scl_c     = (ph != 2'd0);
        sda_low_c = !ph[1];
        if (step) state_nxt = IDLE;
      end
      DEV_W, ADDR_H, ADDR_L, WR_DATA, DEV_R: begin
        scl_c     = scl_mid;
        sda_low_c = !tx_sh[7];
        if (step && last_bit) begin
          case (state)
            DEV_W:   state_nxt = ACK_DW;
            ADDR_H:  state_nxt = ACK_AH;
            ADDR_L:  state_nxt = ACK_AL;
            WR_DATA: state_nxt = ACK_WD;
            default: state_nxt = ACK_DR;
          endcase
        end
      end
      RD_DATA: begin
        scl_c = scl_mid;
        if (step && last_bit) state_nxt = NACK_M;
      end
      NACK_M: begin
        scl_c = scl_mid;
        if (step) state_nxt = STOP;
      end
      default: begin
        // ACK slots: a NACK from the slave aborts straight to STOP
        scl_c = scl_mid;
        if (step) begin
          if (ack_bit) state_nxt = STOP;
          else begin
            case (state)
              ACK_DW:  state_nxt = a16 ? ADDR_H : ADDR_L;
              ACK_AH:  state_nxt = ADDR_L;
              ACK_AL:  state_nxt = op_rd ? RESTART : WR_DATA;
              ACK_DR:  state_nxt = RD_DATA;
              default: state_nxt = STOP;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      tick           <= 1'b0;
      ph             <= 2'd0;
      bit_cnt        <= 3'd0;
      tx_sh          <= 8'h00;
      rx_sh          <= 8'h00;
      ack_bit        <= 1'b0;
      rx_done        <= 1'b0;
      op_rd          <= 1'b0;
      a16            <= 1'b0;
      addr_q         <= 16'h0000;
      wdat_q         <= 8'h00;
      start_q        <= 1'b0;
      sda_s1         <= 1'b1;
      sda_s2         <= 1'b1;
      sda_oe         <= 1'b0;
      scl            <= 1'b1;
      iic_wr_rd_done <= 1'b0;
      rd_data        <= 8'h00;
      busy           <= 1'b0;
      ack_err        <= 1'b0;
    end else begin
      start_q        <= iic_start;
      sda_s1         <= sda;
      sda_s2         <= sda_s1;
      scl            <= scl_c;
      sda_oe         <= sda_low_c;
      iic_wr_rd_done <= 1'b0;
      if (iic_wr_rd_done) busy <= 1'b0;

      if (busy) begin
        cnt  <= (cnt == CW'(CNT_MAX - 1)) ? '0 : cnt + CW'(1);
        tick <= (cnt == CW'(CNT_MAX - 1));
      end else begin
        cnt  <= '0;
        tick <= 1'b0;
      end

      if (accept) begin
        busy    <= 1'b1;
        ack_err <= 1'b0;
        rx_done <= 1'b0;
        op_rd   <= rd_en;
        a16     <= addr_mem;
        addr_q  <= data_addr;
        wdat_q  <= wr_data;
        ph      <= 2'd0;
        bit_cnt <= 3'd0;
      end else if (tick && state != IDLE) begin
        ph <= ph + 2'd1;
        if (ph == 2'd2) begin
          if (state == RD_DATA) rx_sh <= {rx_sh[6:0], sda_s2};
          if (is_ack)           ack_bit <= sda_s2;
        end
        if (step) begin
          if (state_nxt != state) begin
            bit_cnt <= 3'd0;
            case (state_nxt)
              DEV_W:   tx_sh <= {DEVICE_ADDR, 1'b0};
              ADDR_H:  tx_sh <= addr_q[15:8];
              ADDR_L:  tx_sh <= addr_q[7:0];
              WR_DATA: tx_sh <= wdat_q;
              DEV_R:   tx_sh <= {DEVICE_ADDR, 1'b1};
              default: tx_sh <= tx_sh;
            endcase
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            tx_sh   <= {tx_sh[6:0], 1'b0};
          end
          if (is_ack && ack_bit)               ack_err <= 1'b1;
          if (state == RD_DATA && last_bit)    rx_done <= 1'b1;
          if (state == STOP) begin
            iic_wr_rd_done <= 1'b1;
            if (rx_done) rd_data <= rx_sh;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_iic_ctrl.sv
// Directed bench for iic_ctrl: table of transactions against a bus-level EEPROM slave model,
// plus hand-written hold/illegal-request and mid-transaction reset sequences.
module tb_iic_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iic_start = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        addr_mem = 1'b0;
  logic [15:0] data_addr = 16'h0000;
  logic [7:0]  wr_data = 8'h00;
  logic        done;
  logic [7:0]  rd_data;
  logic        busy;
  logic        ack_err;
  logic        scl;
  wire         sda;
  logic        slave_low = 1'b0;

  assign sda = slave_low ? 1'b0 : 1'bz;
  pullup (sda);

  iic_ctrl dut (
    .clk(clk), .rst_n(rst_n), .iic_start(iic_start), .wr_en(wr_en), .rd_en(rd_en),
    .addr_mem(addr_mem), .data_addr(data_addr), .wr_data(wr_data),
    .iic_wr_rd_done(done), .rd_data(rd_data), .busy(busy), .ack_err(ack_err),
    .scl(scl), .sda(sda)
  );

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bus-level slave: logs START(256), STOP(257), received bytes, and master NACK(258).
  int         ev[$];
  int         scl_toggles = 0;
  logic       nack_dev = 1'b0;
  logic [7:0] rdval = 8'h00;
  logic       scl_p = 1'b1, sda_p = 1'b1;
  int         bitcnt = 0, byte_idx = 0;
  logic       tx = 1'b0, devr_pend = 1'b0, ackv;
  logic [7:0] sh = 8'h00;

  always @(negedge clk) begin
    logic c, s;
    c = scl;
    s = sda;
    if (!rst_n) begin
      slave_low = 1'b0; bitcnt = 0; tx = 1'b0; devr_pend = 1'b0;
      scl_p = 1'b1; sda_p = 1'b1;
    end else begin
      if (c !== scl_p) scl_toggles++;
      if (c && scl_p && sda_p && !s) begin
        ev.push_back(256);
        bitcnt = 0; tx = 1'b0; byte_idx = 0; slave_low = 1'b0; devr_pend = 1'b0;
      end else if (c && scl_p && !sda_p && s) begin
        ev.push_back(257);
      end else if (c && !scl_p) begin
        if (bitcnt < 8) begin
          sh = {sh[6:0], s};
          bitcnt++;
          if (bitcnt == 8 && !tx) ev.push_back(int'(sh));
        end else if (bitcnt == 8) begin
          if (tx && s) ev.push_back(258);
          bitcnt = 9;
        end
      end else if (!c && scl_p) begin
        if (!tx) begin
          if (bitcnt == 8) begin
            ackv      = !(nack_dev && byte_idx == 0);
            slave_low = ackv;
            devr_pend = ackv && (byte_idx == 0) && sh[0];
            byte_idx++;
          end else if (bitcnt == 9) begin
            slave_low = 1'b0;
            bitcnt    = 0;
            if (devr_pend) begin
              tx = 1'b1; devr_pend = 1'b0; slave_low = !rdval[7];
            end
          end
        end else begin
          if (bitcnt >= 1 && bitcnt <= 7) slave_low = !rdval[7 - bitcnt];
          else if (bitcnt == 8)           slave_low = 1'b0;
          else if (bitcnt == 9) begin tx = 1'b0; bitcnt = 0; end
        end
      end
      scl_p = c;
      sda_p = s;
    end
  end

  typedef struct {
    logic        wr;
    logic        rd;
    logic        am;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic        nack;
    logic [7:0]  rdv;
    int          cyc;
    logic        aerr;
    logic [7:0]  rdexp;
    int          nev;
  } vec_t;

  vec_t vt[6];
  int   exp_ev[6][8];

  // Starts a request, scrambles the inputs after acceptance, and returns the done edge index.
  task automatic start_txn(input int k, output int cyc);
    wr_en = vt[k].wr; rd_en = vt[k].rd; addr_mem = vt[k].am;
    data_addr = vt[k].addr; wr_data = vt[k].wd;
    nack_dev = vt[k].nack; rdval = vt[k].rdv;
    ev.delete();
    iic_start = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("busy_on_accept[%0d]", k), busy, 1'b1);
    chk($sformatf("ack_err_cleared[%0d]", k), ack_err, 1'b0);
    wr_en = ~wr_en; rd_en = ~rd_en; addr_mem = ~addr_mem;
    data_addr = ~data_addr; wr_data = ~wr_data;
    cyc = -1;
    for (int n = 1; n <= 12000; n++) begin
      @(posedge clk); #1;
      if (done) begin cyc = n; break; end
    end
  endtask

  task automatic apply_vec(input int k);
    int cyc;
    start_txn(k, cyc);
    chk($sformatf("done_cycle[%0d]", k), cyc, vt[k].cyc);
    chk($sformatf("busy_at_done[%0d]", k), busy, 1'b1);
    chk($sformatf("ack_err[%0d]", k), ack_err, vt[k].aerr);
    chk($sformatf("rd_data[%0d]", k), rd_data, vt[k].rdexp);
    @(posedge clk); #1;
    chk($sformatf("done_width[%0d]", k), done, 1'b0);
    chk($sformatf("busy_after[%0d]", k), busy, 1'b0);
    chk($sformatf("ev_count[%0d]", k), ev.size(), vt[k].nev);
    for (int i = 0; i < vt[k].nev; i++)
      chk($sformatf("ev[%0d][%0d]", k, i), (i < ev.size()) ? ev[i] : -1, exp_ev[k][i]);
    // iic_start still high: no second transaction may start
    scl_toggles = 0;
    repeat (300) @(posedge clk);
    #1;
    chk($sformatf("hold_no_retrigger[%0d]", k), {busy, 31'(scl_toggles)}, 32'd0);
    iic_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic done_seen;
    int   cyc;

    vt[0] = '{wr:1, rd:0, am:1, addr:16'h005A, wd:8'h55, nack:0, rdv:8'h00, cyc:7601, aerr:0, rdexp:8'h00, nev:6};
    vt[1] = '{wr:0, rd:1, am:1, addr:16'h005A, wd:8'h00, nack:0, rdv:8'h55, cyc:9601, aerr:0, rdexp:8'h55, nev:8};
    vt[2] = '{wr:1, rd:0, am:0, addr:16'h125A, wd:8'hC3, nack:0, rdv:8'h00, cyc:5801, aerr:0, rdexp:8'h55, nev:5};
    vt[3] = '{wr:0, rd:1, am:0, addr:16'h00F0, wd:8'h00, nack:0, rdv:8'hA6, cyc:7801, aerr:0, rdexp:8'hA6, nev:7};
    vt[4] = '{wr:1, rd:0, am:1, addr:16'h0033, wd:8'h11, nack:1, rdv:8'h00, cyc:2201, aerr:1, rdexp:8'hA6, nev:3};
    vt[5] = '{wr:0, rd:1, am:1, addr:16'h1234, wd:8'h00, nack:0, rdv:8'h3C, cyc:9601, aerr:0, rdexp:8'h3C, nev:8};
    exp_ev[0] = '{256, 'hA0, 'h00, 'h5A, 'h55, 257, 0, 0};
    exp_ev[1] = '{256, 'hA0, 'h00, 'h5A, 256, 'hA1, 258, 257};
    exp_ev[2] = '{256, 'hA0, 'h5A, 'hC3, 257, 0, 0, 0};
    exp_ev[3] = '{256, 'hA0, 'hF0, 256, 'hA1, 258, 257, 0};
    exp_ev[4] = '{256, 'hA0, 257, 0, 0, 0, 0, 0};
    exp_ev[5] = '{256, 'hA0, 'h12, 'h34, 256, 'hA1, 258, 257};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_scl", scl, 1'b1);
    chk("reset_sda", sda, 1'b1);
    chk("reset_done", done, 1'b0);
    chk("reset_rd_data", rd_data, 8'h00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ack_err", ack_err, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    for (int k = 0; k < 6; k++) apply_vec(k);

    // Illegal request: both enables set must be dropped with no bus activity
    wr_en = 1'b1; rd_en = 1'b1; addr_mem = 1'b1;
    scl_toggles = 0;
    done_seen = 1'b0;
    iic_start = 1'b1;
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      if (done || busy) done_seen = 1'b1;
    end
    chk("illegal_no_busy_done", done_seen, 1'b0);
    chk("illegal_no_scl", scl_toggles, 0);
    iic_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset right after tick 60 of a write
    wr_en = 1'b1; rd_en = 1'b0; addr_mem = 1'b1; data_addr = 16'h005A; wr_data = 8'h55;
    nack_dev = 1'b0;
    iic_start = 1'b1;
    @(posedge clk); #1;
    repeat (3001) @(posedge clk);
    #1;
    chk("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_scl", scl, 1'b1);
    chk("midrst_sda", sda, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    @(posedge clk); #1;
    chk("midrst_busy_next", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    iic_start = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    start_txn(0, cyc);
    chk("post_reset_done_cycle", cyc, 7601);
    chk("post_reset_ack_err", ack_err, 1'b0);
    chk("post_reset_ev_count", ev.size(), 6);
    iic_start = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
